// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: loads a word, shifts it out MSB-first on enable, repeated N+1 times.
// Define SEQ_PATTERN_TX_PREAMBLE_EN to emit a 1,1,1,1,0 marker before every copy.
module seq_pattern_tx #(
    parameter int WIDTH    = 8,
    parameter int REPEAT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [WIDTH-1:0]    load_data,
    input  logic [REPEAT_W-1:0] load_repeat,
    input  logic                enable,
    output logic                tx_bit,
    output logic                tx_valid,
    output logic                tx_last,
    output logic                busy
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd2;
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
    localparam logic [1:0] S_PRE   = 2'd1;
    localparam logic [1:0] S_FIRST = S_PRE;
`else
    localparam logic [1:0] S_FIRST = S_DATA;
`endif

    logic [1:0]          state;
    logic [WIDTH-1:0]    word;
    logic [WIDTH-1:0]    shreg;
    logic [CNT_W-1:0]    bit_cnt;
    logic [REPEAT_W-1:0] rep_cnt;
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
    logic [2:0]          pre_cnt;
`endif

    // Stay busy through the tx_last cycle so the idle gap is visible downstream.
    assign busy       = (state != S_IDLE) || tx_last;
    assign load_ready = !busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            word     <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            rep_cnt  <= '0;
            tx_bit   <= 1'b0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
            pre_cnt  <= '0;
`endif
        end else begin
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_valid && load_ready) begin
                        word    <= load_data;
                        shreg   <= load_data;
                        rep_cnt <= load_repeat;
                        bit_cnt <= '0;
                        state   <= S_FIRST;
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
                        pre_cnt <= '0;
`endif
                    end
                end
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
                S_PRE: begin
                    if (enable) begin
                        tx_valid <= 1'b1;
                        tx_bit   <= (pre_cnt != 3'd4);
                        if (pre_cnt == 3'd4) begin
                            pre_cnt <= '0;
                            state   <= S_DATA;
                        end else begin
                            pre_cnt <= pre_cnt + 3'd1;
                        end
                    end
                end
`endif
                S_DATA: begin
                    if (enable) begin
                        tx_valid <= 1'b1;
                        tx_bit   <= shreg[WIDTH-1];
                        shreg    <= {shreg[WIDTH-2:0], 1'b0};
                        if (bit_cnt == LAST_IDX) begin
                            bit_cnt <= '0;
                            if (rep_cnt != '0) begin
                                rep_cnt <= rep_cnt - 1'b1;
                                shreg   <= word;
                                state   <= S_FIRST;
                            end else begin
                                tx_last <= 1'b1;
                                state   <= S_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: the sending end of the serial bit-stream links that our sequence detectors consume. Accepts a parallel word through a valid/ready load port and shifts it out MSB-first, one bit per enabled clock. The word can be repeated a programmable number of times. An optional start marker of four ones and a zero can be compiled in ahead of each copy, so a downstream 1111 detector can frame the data.

## Interface

- WIDTH, 8, payload word width in bits (≥2)
- REPEAT_W, 4, width of the repeat-count field
- clk  input  1  clock, all logic on rising edge
- reset  input  1  reset, synchronous, active-high; clock clk
- load_valid  input  1  load request
- load_ready  output  1  block idle, can accept a load
- load_data  input  WIDTH  word to transmit
- load_repeat  input  REPEAT_W  transmit count minus one (0 → 1 copy, 15 → 16 copies)
- enable  input  1  bit-rate strobe; the block advances only when high
- tx_bit  output  1  serial data
- tx_valid  output  1  tx_bit is a transmitted bit this cycle
- tx_last  output  1  final bit of the final copy
- busy  output  1  transfer in progress

## Operation

- States:
  - IDLE: waits for a load.
  - PRE: marker, present only with the macro.
  - DATA: shifts out the payload.
- IDLE:
  - load_ready=1.
  - A handshake occurs when load_valid&&load_ready on a rising edge.
  - On handshake, latch load_data into the shift register and load_repeat into the repeat counter.
  - Go to PRE if compiled in, else DATA. busy=1 and load_ready=0 from the next cycle.
- PRE (per copy): emits 1,1,1,1,0 (5 bits), then goes to DATA.
- DATA:
  - Emits bits WIDTH-1 down to 0 of the latched word.
  - After bit 0:
    - If the repeat counter is nonzero: decrement it, reload the shift register from the latched word, and go to PRE (or restart DATA).
    - Otherwise go to IDLE.
- Stall: in PRE/DATA with enable=0:
  - tx_valid=0, tx_last=0.
  - tx_bit holds its last value.
  - No state, counter or shift change.
- tx_last=1 only together with tx_valid=1 on bit 0 of the final copy.
- Loads in PRE/DATA are ignored (load_ready=0). The latched word and count are unaffected by load_data changes.
- Reset (any state, including mid-transfer): go to IDLE. Outputs: tx_bit=0, tx_valid=0, tx_last=0, busy=0, load_ready=1. Counters and shift register cleared. A partially sent word is abandoned; there is no resume.
- Bit counter width: ceil(log2(WIDTH)). The repeat counter never wraps: it stops at 0.

## Timing

- Handshake in cycle T. First bit is valid in cycle T+1 if enable=1 in T+1.
- Per copy, without stalls: WIDTH cycles (WIDTH+5 with marker). A full transfer is (load_repeat+1)×(WIDTH[+5]) enabled cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- tx_last in cycle L. In cycle L+1: busy=0, load_ready=1. Earliest next handshake is L+1, so the minimum inter-word gap is 1 idle cycle.
- enable is sampled every cycle. It has no effect in IDLE.

## Configuration

- SEQ_PATTERN_TX_PREAMBLE_EN defined:
  - PRE state present.
  - Every copy is preceded by 1,1,1,1,0.
- Macro undefined:
  - PRE state and its counter removed.
  - Copies are sent back-to-back with no marker.
- Interface identical in both builds.

## Test plan

- Single word, macro off: load_data=0xA5, load_repeat=0, enable=1.
  - tx_bit=1,0,1,0,0,1,0,1 in cycles T+1..T+8, tx_valid=1 throughout.
  - tx_last only at T+8; load_ready=1 at T+9.
- Marker, macro on: load_data=0x3C, load_repeat=0.
  - Stream 1,1,1,1,0,0,0,1,1,1,1,0,0 over 13 cycles; tx_last on the 13th.
- Repeat: load_data=0x81, load_repeat=2, macro off.
  - 24 valid bits (10000001 ×3); tx_last only on bit 24.
  - busy=1 for 24 cycles.
- Stall: enable low for 3 cycles after the 4th bit of 0xF0.
  - tx_valid=0 and tx_bit held at 1 during the stall.
  - Stream resumes 0,0,0,0; total span 11 cycles.
- Reset mid-word: assert reset after bit 3 of 0xFF.
  - Next cycle: tx_valid=0, busy=0, load_ready=1.
  - A new load of 0x01 transmits cleanly as 00000001.
- Load while busy: pulse load_valid with 0x00 during the transfer of 0xAA.
  - Ignored; stream is exactly 10101010.
